// File: rtl/fetch_bytes_if.sv
// fetch_bytes_if
// Bundles the prefetch-FIFO head interface and the decode-side byte stream
// of the fetch stage.
//   slave  : view of the fetch_bytes block (consumes FIFO head, drives fetch)
//   master : view of the surrounding pipeline / testbench
// Signals:
//   fetch_flush     discard everything buffered (branch, exception)
//   pf_valid        FIFO head valid
//   pf_data         head packet, byte0 = lowest linear address
//   pf_len          valid bytes in pf_data, 1..OUT_BYTES
//   pf_fault        head is a fault marker with no bytes
//   pf_rd           pop the FIFO head this cycle
//   dec_acceptable  bytes decode can take this cycle, 0..12
//   fetch           byte0 = next instruction byte, invalid bytes zero
//   fetch_valid     valid bytes in fetch
//   fetch_fault     all bytes before the fault delivered, fault pending
interface fetch_bytes_if #(
  parameter int OUT_BYTES = 8
);
  logic                   fetch_flush;
  logic                   pf_valid;
  logic [8*OUT_BYTES-1:0] pf_data;
  logic [3:0]             pf_len;
  logic                   pf_fault;
  logic                   pf_rd;
  logic [3:0]             dec_acceptable;
  logic [8*OUT_BYTES-1:0] fetch;
  logic [3:0]             fetch_valid;
  logic                   fetch_fault;

  modport slave (
    input  fetch_flush, pf_valid, pf_data, pf_len, pf_fault, dec_acceptable,
    output pf_rd, fetch, fetch_valid, fetch_fault
  );

  modport master (
    output fetch_flush, pf_valid, pf_data, pf_len, pf_fault, dec_acceptable,
    input  pf_rd, fetch, fetch_valid, fetch_fault
  );
endinterface

// File: rtl/fetch_bytes.sv
// fetch_bytes
// Producer side of the fetch->decode byte stream. Pops variable-length packets
// from the prefetch FIFO into a byte-aligned staging buffer and presents up to
// OUT_BYTES contiguous instruction bytes to decode. Every cycle it retires
// min(dec_acceptable, fetch_valid) bytes. A fault marker popped from the FIFO
// is reported on fetch_fault only once every byte ahead of it has drained.
// Ports:
//   clk  clock
//   rst  asynchronous, active-high reset
//   bus  fetch_bytes_if.slave (FIFO head in, decode byte stream out)
// The interface widths (4-bit lengths/counts) are sized for OUT_BYTES = 8 and
// BUF_BYTES = 16.
module fetch_bytes #(
  parameter int BUF_BYTES = 16,
  parameter int OUT_BYTES = 8
) (
  input  logic          clk,
  input  logic          rst,
  fetch_bytes_if.slave  bus
);

  localparam int BW = BUF_BYTES * 8;
  localparam int OW = OUT_BYTES * 8;
  localparam int CW = $clog2(BUF_BYTES + 1);

  logic [BW-1:0] buf_r;
  logic [CW-1:0] cnt_r;
  logic          fault_r;

  logic [BW-1:0] buf_nxt_s;
  logic [CW-1:0] cnt_nxt_s;
  logic          fault_nxt_s;

  logic [3:0]    valid_s;
  logic [3:0]    accepted_s;
  logic [3:0]    len_s;
  logic          pop_s;
  logic          push_s;
  logic [OW-1:0] fetch_s;
  logic [OW-1:0] data_masked_s;
  logic [CW-1:0] after_s;
  logic [BW-1:0] shifted_s;
  logic [BW-1:0] keep_mask_s;
  logic [BW-1:0] ins_s;

  // Presented bytes, retire amount, pop decision and clamped packet length.
  always_comb begin
    valid_s    = 4'd0;
    fetch_s    = '0;
    accepted_s = 4'd0;
    len_s      = 4'(OUT_BYTES);

    if (bus.fetch_flush) begin
      valid_s = 4'd0;
    end else if (cnt_r > CW'(OUT_BYTES)) begin
      valid_s = 4'(OUT_BYTES);
    end else begin
      valid_s = 4'(cnt_r);
    end

    // Bytes past fetch_valid are forced to zero so stale buffer contents
    // never leak to decode.
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (4'(i) < valid_s) begin
        fetch_s[8*i +: 8] = buf_r[8*i +: 8];
      end else begin
        fetch_s[8*i +: 8] = 8'h00;
      end
    end

    if (bus.dec_acceptable < valid_s) begin
      accepted_s = bus.dec_acceptable;
    end else begin
      accepted_s = valid_s;
    end

    // Pop only looks at the registered count, so there is always room for a
    // full packet on top of whatever has not yet been retired. Reset also
    // blocks the pop so no head is lost while the buffer is being cleared.
    pop_s  = bus.pf_valid & ~bus.fetch_flush & ~fault_r & ~rst &
             (cnt_r <= CW'(BUF_BYTES - OUT_BYTES));
    push_s = pop_s & ~bus.pf_fault;

    // Out-of-range lengths are a protocol error; treat them as a full packet.
    if ((bus.pf_len == 4'd0) || (bus.pf_len > 4'(OUT_BYTES))) begin
      len_s = 4'(OUT_BYTES);
    end else begin
      len_s = bus.pf_len;
    end
  end

  // Next buffer contents: shift out retired bytes, append the popped packet.
  always_comb begin
    data_masked_s = '0;
    after_s       = cnt_r - CW'(accepted_s);
    shifted_s     = buf_r >> {accepted_s, 3'b000};
    keep_mask_s   = ~({BW{1'b1}} << {after_s, 3'b000});
    buf_nxt_s     = buf_r;
    cnt_nxt_s     = cnt_r;
    fault_nxt_s   = fault_r;

    for (int i = 0; i < OUT_BYTES; i++) begin
      if (4'(i) < len_s) begin
        data_masked_s[8*i +: 8] = bus.pf_data[8*i +: 8];
      end else begin
        data_masked_s[8*i +: 8] = 8'h00;
      end
    end
    ins_s = {{(BW - OW){1'b0}}, data_masked_s} << {after_s, 3'b000};

    if (bus.fetch_flush) begin
      buf_nxt_s   = buf_r;
      cnt_nxt_s   = {CW{1'b0}};
      fault_nxt_s = 1'b0;
    end else if (push_s) begin
      buf_nxt_s   = (shifted_s & keep_mask_s) | ins_s;
      cnt_nxt_s   = after_s + CW'(len_s);
      fault_nxt_s = fault_r;
    end else begin
      buf_nxt_s   = shifted_s & keep_mask_s;
      cnt_nxt_s   = after_s;
      fault_nxt_s = fault_r | (pop_s & bus.pf_fault);
    end
  end

  // Staging buffer, byte count and pending-fault state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r   <= {BW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      fault_r <= 1'b0;
    end else begin
      buf_r   <= buf_nxt_s;
      cnt_r   <= cnt_nxt_s;
      fault_r <= fault_nxt_s;
    end
  end

  assign bus.pf_rd       = pop_s;
  assign bus.fetch       = fetch_s;
  assign bus.fetch_valid = valid_s;
  assign bus.fetch_fault = fault_r & (cnt_r == {CW{1'b0}}) & ~bus.fetch_flush;

  fetch_bytes_chk #(
    .BUF_BYTES (BUF_BYTES),
    .OUT_BYTES (OUT_BYTES),
    .CW        (CW)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .pf_rd    (pop_s),
    .pf_fault (bus.pf_fault),
    .pf_len   (bus.pf_len),
    .cnt      (cnt_r)
  );

endmodule

// fetch_bytes_chk
// Simulation-only protocol checks for fetch_bytes.
//   pf_rd/pf_fault/pf_len  popped head; a data packet must carry 1..OUT_BYTES
//   cnt                    buffer occupancy, never above BUF_BYTES
module fetch_bytes_chk #(
  parameter int BUF_BYTES = 16,
  parameter int OUT_BYTES = 8,
  parameter int CW        = 5
) (
  input logic          clk,
  input logic          rst,
  input logic          pf_rd,
  input logic          pf_fault,
  input logic [3:0]    pf_len,
  input logic [CW-1:0] cnt
);

  a_pf_len_legal : assert property (@(posedge clk) disable iff (rst)
    (pf_rd && !pf_fault) |-> ((pf_len != 4'd0) && (pf_len <= 4'(OUT_BYTES))));

  a_cnt_bound : assert property (@(posedge clk) disable iff (rst)
    cnt <= CW'(BUF_BYTES));

endmodule
